// File: rtl/seq_det_101_mealy.sv
// ----------------------------------------------------------------------------
// seq_det_101_mealy
//   Serial 1-0-1 pattern detector, Mealy style. One bit of x is consumed on
//   every rising clk edge; y flags, combinationally, the cycle in which the
//   presented x completes a 1-0-1 run.
//
//   Parameters
//     OVERLAP : 1 = the final 1 of a match also starts the next candidate
//               0 = after a match the detector starts again from scratch
//
//   Ports
//     clk : system clock, rising-edge active
//     rst : asynchronous reset, active low (0 = held in reset)
//     x   : serial data bit, sampled on each rising clk edge
//     y   : detect flag, combinational from state and x (zero-cycle latency)
// ----------------------------------------------------------------------------
module seq_det_101_mealy #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);

    typedef enum logic [1:0] {
        S0  = 2'b00,   // no progress
        S1  = 2'b01,   // last bit was 1
        S10 = 2'b10,   // last two bits were 1,0
        SX  = 2'b11    // unused code, recovers to S0
    } state_t;

    state_t state, nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S0;
        else      state <= nxt;
    end

    always_comb begin
        nxt = S0;
        y   = 1'b0;
        case (state)
            S0:  nxt = x ? S1 : S0;
            // A run of 1s keeps the most recent 1 as the candidate start.
            S1:  nxt = x ? S1 : S10;
            S10: begin
                if (x) begin
                    nxt = OVERLAP ? S1 : S0;
                    y   = rst;   // output is forced low while reset is held
                end else begin
                    nxt = S0;
                end
            end
            default: begin
                nxt = S0;
                y   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_det_101_mealy.sv
// ----------------------------------------------------------------------------
// tb_seq_det_101_mealy
//   Bench for seq_det_101_mealy. Two instances (OVERLAP=1 and OVERLAP=0) share
//   the same clk/rst/x. Inputs change on the falling edge; y is sampled 1ns
//   later, well away from the rising edge.
//   Reference model: the bits seen since the last restart point are kept in a
//   queue; a match is "last two stored bits are 1,0 and current x is 1".
//   Restart points are reset, and (non-overlap only) each match.
// ----------------------------------------------------------------------------
module tb_seq_det_101_mealy;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic y_ov, y_no;

    always #5 clk = ~clk;

    seq_det_101_mealy #(.OVERLAP(1'b1)) u_ov (.clk(clk), .rst(rst), .x(x), .y(y_ov));
    seq_det_101_mealy #(.OVERLAP(1'b0)) u_no (.clk(clk), .rst(rst), .x(x), .y(y_no));

    int ntests = 0;
    int nfail  = 0;

    // history of bits since the last restart, per variant
    bit h_ov[$];
    bit h_no[$];

    typedef struct {
        logic r;
        logic b;
        logic e_ov;
        logic e_no;
    } vec_t;

    function automatic bit match(input bit h[$], input logic b);
        int n;
        n = h.size();
        return (n >= 2) && h[n-2] && !h[n-1] && (b === 1'b1);
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: y=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_clear();
        h_ov.delete();
        h_no.delete();
    endtask

    // Model update at a rising edge, using the x value present at that edge.
    task automatic mdl_edge();
        bit m_no;
        if (!rst) begin
            mdl_clear();
        end else begin
            m_no = match(h_no, x);
            h_ov.push_back(x);
            if (h_ov.size() > 2) void'(h_ov.pop_front());
            if (m_no) h_no.delete();
            else begin
                h_no.push_back(x);
                if (h_no.size() > 2) void'(h_no.pop_front());
            end
        end
    endtask

    // One cycle: called just after a falling edge; drives, checks, and
    // returns just after the next falling edge.
    task automatic cyc(input logic r, input logic b, input logic e_ov,
                       input logic e_no, input string nm);
        rst = r;
        x   = b;
        if (!r) mdl_clear();
        #1;
        chk({nm, "/ov"}, y_ov, e_ov);
        chk({nm, "/no"}, y_no, e_no);
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    // Same, but expectations come from the reference model.
    task automatic cyc_m(input logic r, input logic b, input string nm);
        logic e_ov, e_no;
        if (!r) mdl_clear();
        e_ov = r & match(h_ov, b);
        e_no = r & match(h_no, b);
        cyc(r, b, e_ov, e_no, nm);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b0;
        x   = 1'b0;

        // reset held with x toggling, then release and 1,0,1
        tbl.push_back('{0,1,0,0}); tbl.push_back('{0,0,0,0});
        tbl.push_back('{0,1,0,0}); tbl.push_back('{0,0,0,0});
        tbl.push_back('{0,1,0,0});
        tbl.push_back('{1,1,0,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,1,1});
        // reset, then 0,1,1,1,0,1 : match only on the 6th bit
        tbl.push_back('{0,0,0,0});
        tbl.push_back('{1,0,0,0}); tbl.push_back('{1,1,0,0});
        tbl.push_back('{1,1,0,0}); tbl.push_back('{1,1,0,0});
        tbl.push_back('{1,0,0,0}); tbl.push_back('{1,1,1,1});
        // continue 0,0,1,0,1 : the 0,0 breaks the pattern
        tbl.push_back('{1,0,0,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,0,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,1,1});
        // reset, then 1,0,1,0,1,0,0 : overlap hits bits 3 and 5
        tbl.push_back('{0,0,0,0});
        tbl.push_back('{1,1,0,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,1,1}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,1,1,0}); tbl.push_back('{1,0,0,0});
        tbl.push_back('{1,0,0,0});

        @(negedge clk);
        foreach (tbl[i])
            cyc(tbl[i].r, tbl[i].b, tbl[i].e_ov, tbl[i].e_no, $sformatf("tbl%0d", i));

        // mid-sequence asynchronous reset: 1,0, reset pulse, then 1 -> no hit
        cyc(0, 0, 0, 0, "mr_rst");
        cyc(1, 1, 0, 0, "mr_1");
        x = 1'b0;                       // would sit in S10 after this edge
        #1; chk("mr_0/ov", y_ov, 1'b0); chk("mr_0/no", y_no, 1'b0);
        @(posedge clk); mdl_edge();
        @(negedge clk);
        x = 1'b1;
        #1; chk("mr_pre/ov", y_ov, 1'b1); chk("mr_pre/no", y_no, 1'b1);
        rst = 1'b0; mdl_clear();
        #1; chk("mr_inrst/ov", y_ov, 1'b0); chk("mr_inrst/no", y_no, 1'b0);
        #1; rst = 1'b1;
        #1; chk("mr_after/ov", y_ov, 1'b0); chk("mr_after/no", y_no, 1'b0);
        @(posedge clk); mdl_edge();
        @(negedge clk);
        cyc(1, 0, 0, 0, "mr_a0");
        cyc(1, 1, 1, 1, "mr_a1");

        // combinational path: in S10, toggle x within the low phase
        cyc(0, 0, 0, 0, "cb_rst");
        cyc(1, 1, 0, 0, "cb_1");
        cyc(1, 0, 0, 0, "cb_0");
        x = 1'b0; #1; chk("cb_lo0/ov", y_ov, 1'b0); chk("cb_lo0/no", y_no, 1'b0);
        x = 1'b1; #1; chk("cb_hi/ov",  y_ov, 1'b1); chk("cb_hi/no",  y_no, 1'b1);
        x = 1'b0; #1; chk("cb_lo1/ov", y_ov, 1'b0); chk("cb_lo1/no", y_no, 1'b0);
        @(posedge clk); mdl_edge();     // x=0 at the edge: back to S0
        @(negedge clk);
        cyc(1, 1, 0, 0, "cb_post");     // no stale S10 left behind

        // randomized stream with occasional resets
        cyc_m(0, 1'b0, "rnd_rst");
        for (int i = 0; i < 600; i++) begin
            logic r, b;
            r = ($urandom_range(39) != 0);
            b = logic'($urandom_range(1));
            cyc_m(r, b, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // hard stop in case the clocked sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
